// File: rtl/sparc_ifu_thrreq.sv
// Per-thread request holding queue feeding the IFU 4-way round-robin arbiter.
// Holds one request per thread, issues granted requests with one-cycle latency.
module sparc_ifu_thrreq #(
  parameter int DW = 40,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          arst_l,
  input  logic          post_vld,
  input  logic [1:0]    post_tid,
  input  logic [DW-1:0] post_data,
  output logic [3:0]    post_rdy,
  output logic          post_ovf,
  input  logic [3:0]    kill_vec,
  output logic [3:0]    req_vec,
  input  logic [3:0]    grant_vec,
  output logic          arb_advance,
  input  logic          issue_stall,
  output logic          issue_vld,
  output logic [1:0]    issue_tid,
  output logic [DW-1:0] issue_data,
  output logic          gnt_err,
  output logic [3:0]    starve_vec
);

  localparam logic [CW-1:0] CMAX = '1;

  logic [3:0]    slot_vld_q;
  logic [3:0]    slot_vld_d;
  logic [DW-1:0] slot_data_q [4];
  logic [DW-1:0] slot_data_d [4];
  logic [CW-1:0] wait_cnt_q [4];
  logic [CW-1:0] wait_cnt_d [4];

  logic          issue_vld_q;
  logic          issue_vld_d;
  logic [1:0]    issue_tid_q;
  logic [1:0]    issue_tid_d;
  logic [DW-1:0] issue_data_q;
  logic [DW-1:0] issue_data_d;
  logic          post_ovf_q;
  logic          post_ovf_d;
  logic          gnt_err_q;
  logic          gnt_err_d;

  logic [3:0] hit;
  logic       gnt_multi;
  logic       gnt_one;
  logic       take;
  logic [1:0] gnt_tid;
  logic [3:0] take_vec;
  logic       post_acc;
  logic [3:0] post_vec;

  assign req_vec   = slot_vld_q & ~kill_vec;
  assign post_rdy  = ~slot_vld_q;
  assign hit       = grant_vec & req_vec;
  assign gnt_multi = |(grant_vec & (grant_vec - 4'd1));
  assign gnt_one   = (|grant_vec) & ~gnt_multi;
  assign take      = ~issue_stall & (|hit) & gnt_one;
  assign take_vec  = grant_vec & {4{take}};

  assign arb_advance = take;

  assign post_acc = post_vld
                  & ~slot_vld_q[post_tid]
                  & ~kill_vec[post_tid];
  assign post_vec = post_acc ? (4'd1 << post_tid) : 4'd0;

  // Encoder must tolerate multi-bit grants; only used when one-hot.
  always_comb begin
    gnt_tid = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (grant_vec[i]) gnt_tid = 2'(i);
    end
  end

  always_comb begin
    for (int t = 0; t < 4; t++) begin
      slot_vld_d[t]  = slot_vld_q[t];
      slot_data_d[t] = slot_data_q[t];
      wait_cnt_d[t]  = wait_cnt_q[t];
      if (kill_vec[t]) begin
        slot_vld_d[t] = 1'b0;
      end else if (take_vec[t]) begin
        slot_vld_d[t] = 1'b0;
      end else if (post_vec[t]) begin
        slot_vld_d[t] = 1'b1;
      end
      if (post_vec[t]) slot_data_d[t] = post_data;
      if (kill_vec[t] | take_vec[t]) begin
        wait_cnt_d[t] = '0;
      end else if (slot_vld_q[t]) begin
        if (wait_cnt_q[t] != CMAX) begin
          wait_cnt_d[t] = wait_cnt_q[t] + CW'(1);
        end
      end else begin
        wait_cnt_d[t] = '0;
      end
    end
  end

  always_comb begin
    issue_vld_d  = take;
    issue_tid_d  = issue_tid_q;
    issue_data_d = issue_data_q;
    if (take) begin
      issue_tid_d  = gnt_tid;
      issue_data_d = slot_data_q[gnt_tid];
    end
    post_ovf_d = post_vld & ~post_acc;
    gnt_err_d  = gnt_multi;
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      slot_vld_q   <= '0;
      issue_vld_q  <= 1'b0;
      issue_tid_q  <= '0;
      issue_data_q <= '0;
      post_ovf_q   <= 1'b0;
      gnt_err_q    <= 1'b0;
      for (int t = 0; t < 4; t++) begin
        slot_data_q[t] <= '0;
        wait_cnt_q[t]  <= '0;
      end
    end else begin
      slot_vld_q   <= slot_vld_d;
      issue_vld_q  <= issue_vld_d;
      issue_tid_q  <= issue_tid_d;
      issue_data_q <= issue_data_d;
      post_ovf_q   <= post_ovf_d;
      gnt_err_q    <= gnt_err_d;
      for (int t = 0; t < 4; t++) begin
        slot_data_q[t] <= slot_data_d[t];
        wait_cnt_q[t]  <= wait_cnt_d[t];
      end
    end
  end

  always_comb begin
    for (int t = 0; t < 4; t++) begin
      starve_vec[t] = (wait_cnt_q[t] == CMAX) & slot_vld_q[t];
    end
  end

  assign issue_vld  = issue_vld_q;
  assign issue_tid  = issue_tid_q;
  assign issue_data = issue_data_q;
  assign post_ovf   = post_ovf_q;
  assign gnt_err    = gnt_err_q;

endmodule
